// File: rtl/change_event_logger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : change_event_logger_pkg
//  Description : Shared definitions for the change event logger. Holds the
//                default sizes, the event-word width helper and the field
//                packing/unpacking helpers used by the top and its FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package change_event_logger_pkg;

  localparam int TS_WIDTH_DEFAULT   = 16;
  localparam int DEPTH_DEFAULT      = 4;
  localparam int DROP_WIDTH_DEFAULT = 8;

  // An event word is {value, time}: the value bit sits at the MSB and the
  // timestamp occupies the low ts_width bits.
  function automatic int event_w(input int ts_width);
    return 1 + ts_width;
  endfunction

  function automatic int value_bit(input int ts_width);
    return ts_width;
  endfunction

endpackage : change_event_logger_pkg
`default_nettype wire

// File: rtl/change_event_logger_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. The head entry is
//                visible on pop_data whenever the FIFO is non-empty and reads
//                as zero when empty. A push while full is accepted only when
//                a pop happens on the same edge.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pop only when there is something to pop; a full FIFO takes a push only
  // if the head is leaving on the same edge.
  always_comb begin
    empty    = (count == '0);
    full     = (count == LW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    level    = count;
    pop_data = empty ? '0 : mem[rd_ptr];
  end

  // Storage carries no reset: emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/change_event_logger.sv
`default_nettype none
// ============================================================================
//  Module      : change_event_logger
//  Description : Samples a 1-bit result every enabled cycle, timestamps each
//                change of value and queues it in a small FWFT FIFO that is
//                drained through a valid/ready stream. Changes that find the
//                FIFO full are counted in a saturating drop counter.
//  Revision    : 1.0  initial release
// ============================================================================
module change_event_logger
  import change_event_logger_pkg::*;
#(
  parameter int TS_WIDTH   = TS_WIDTH_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int DROP_WIDTH = DROP_WIDTH_DEFAULT,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  z_in,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic                  ev_value,
  output logic [TS_WIDTH-1:0]   ev_time,
  output logic [DROP_WIDTH-1:0] drop_cnt,
  output logic [LW-1:0]         fifo_level
);

  localparam int EVENT_W = event_w(TS_WIDTH);
  localparam int VAL_BIT = value_bit(TS_WIDTH);

  logic [TS_WIDTH-1:0] ts;
  logic                primed;
  logic                z_last;
  logic                push_req;
  logic                pop_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;
  logic [EVENT_W-1:0]  push_data;
  logic [EVENT_W-1:0]  head;

  // A change is only meaningful once the first enabled sample has primed
  // z_last; the event carries the timestamp before this edge's increment.
  always_comb begin
    push_req  = en && primed && (z_in != z_last);
    pop_req   = ev_valid && ev_ready;
    drop      = push_req && fifo_full && !pop_req;
    push_data = {z_in, ts};
    ev_valid  = !fifo_empty;
    ev_value  = head[VAL_BIT];
    ev_time   = head[TS_WIDTH-1:0];
  end

  // Timestamp, priming and last-seen value all freeze while en is low;
  // z_last follows the input even when the event itself is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts     <= '0;
      primed <= 1'b0;
      z_last <= 1'b0;
    end else if (en) begin
      ts     <= ts + 1'b1;
      primed <= 1'b1;
      z_last <= z_in;
    end
  end

  // Lost events are counted up to all-ones and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {DROP_WIDTH{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop_req),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule : change_event_logger
`default_nettype wire

// File: tb/tb_change_event_logger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_event_logger
//  Description : Self-checking bench for change_event_logger. A queue-based
//                model of the event log is stepped each clock and compared
//                against the DUT outputs every cycle, with directed scenarios
//                followed by a randomized run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_change_event_logger;

  localparam int TSW   = 4;
  localparam int DEP   = 4;
  localparam int DRW   = 3;
  localparam int LWID  = $clog2(DEP) + 1;
  localparam int TSMOD = 1 << TSW;
  localparam int DMAX  = (1 << DRW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            z_in = 1'b0;
  logic            ev_ready = 1'b0;
  logic            ev_valid;
  logic            ev_value;
  logic [TSW-1:0]  ev_time;
  logic [DRW-1:0]  drop_cnt;
  logic [LWID-1:0] fifo_level;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int m_ts;
  bit m_primed;
  bit m_zlast;
  int m_drop;
  int q_val[$];
  int q_time[$];

  change_event_logger #(
    .TS_WIDTH   (TSW),
    .DEPTH      (DEP),
    .DROP_WIDTH (DRW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .z_in       (z_in),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_value   (ev_value),
    .ev_time    (ev_time),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ts = 0;
    m_primed = 0;
    m_zlast = 0;
    m_drop = 0;
    q_val.delete();
    q_time.delete();
  endtask

  // One clock edge of the logger, written from the behavioural rules.
  task automatic model_step();
    bit pop;
    bit room;
    pop  = ev_ready && (q_val.size() > 0);
    room = (q_val.size() < DEP) || pop;
    if (pop) begin
      void'(q_val.pop_front());
      void'(q_time.pop_front());
    end
    if (en) begin
      if (!m_primed) begin
        m_primed = 1;
        m_zlast  = z_in;
      end else if (z_in != m_zlast) begin
        m_zlast = z_in;
        if (room) begin
          q_val.push_back(int'(z_in));
          q_time.push_back(m_ts);
        end else if (m_drop < DMAX) begin
          m_drop++;
        end
      end
      m_ts = (m_ts + 1) % TSMOD;
    end
  endtask

  task automatic check_all();
    int n;
    n = q_val.size();
    chk("ev_valid",   int'(ev_valid),   (n > 0) ? 1 : 0);
    chk("ev_value",   int'(ev_value),   (n > 0) ? q_val[0] : 0);
    chk("ev_time",    int'(ev_time),    (n > 0) ? q_time[0] : 0);
    chk("drop_cnt",   int'(drop_cnt),   m_drop);
    chk("fifo_level", int'(fifo_level), n);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  // Assert reset between edges so the asynchronous clear is observed, hold
  // it across one edge, release at a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Idle with a constant input: nothing is ever logged.
    en = 1; z_in = 0; ev_ready = 0;
    repeat (10) tick();
    chk("t1_valid", int'(ev_valid), 0);
    chk("t1_drop",  int'(drop_cnt), 0);
    chk("t1_level", int'(fifo_level), 0);

    // Single change at ts=2, then popped.
    do_reset();
    en = 1; z_in = 0; ev_ready = 0;
    tick(); tick();
    z_in = 1;
    tick();
    chk("t2_valid", int'(ev_valid), 1);
    chk("t2_value", int'(ev_value), 1);
    chk("t2_time",  int'(ev_time), 2);
    ev_ready = 1;
    tick();
    ev_ready = 0;
    chk("t2_level_after_pop", int'(fifo_level), 0);

    // Six changes into a four-entry FIFO with no consumer.
    do_reset();
    en = 1; z_in = 0; ev_ready = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      z_in = ~z_in;
      tick();
    end
    chk("t3_level", int'(fifo_level), 4);
    chk("t3_drop",  int'(drop_cnt), 2);
    chk("t3_head_time", int'(ev_time), 1);

    // Full FIFO with pop and push on the same edge.
    ev_ready = 1; z_in = ~z_in;
    tick();
    ev_ready = 0;
    chk("t4_level", int'(fifo_level), 4);
    chk("t4_drop",  int'(drop_cnt), 2);
    chk("t4_head_time", int'(ev_time), 2);
    chk("t4_head_value", int'(ev_value), 0);

    // Keep toggling while full: the drop counter saturates.
    for (int i = 0; i < 10; i++) begin
      z_in = ~z_in;
      tick();
    end
    chk("t4_drop_sat", int'(drop_cnt), DMAX);

    // Timestamp wrap: changes at ts=15 and ts=0.
    do_reset();
    en = 1; z_in = 0; ev_ready = 0;
    repeat (15) tick();
    z_in = 1; tick();
    z_in = 0; tick();
    chk("t5_level", int'(fifo_level), 2);
    chk("t5_time_a", int'(ev_time), 15);
    ev_ready = 1; tick(); ev_ready = 0;
    chk("t5_time_b", int'(ev_time), 0);

    // en low: changes wait and are reported on the next enabled edge.
    en = 0; z_in = 1; tick(); tick();
    chk("en0_level", int'(fifo_level), 1);
    en = 1; tick();
    chk("en1_level", int'(fifo_level), 2);

    // Reset with three events queued; the first edge after release primes.
    do_reset();
    en = 1; z_in = 0; ev_ready = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      z_in = ~z_in;
      tick();
    end
    chk("t6_level_pre", int'(fifo_level), 3);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("t6_valid_rst", int'(ev_valid), 0);
    chk("t6_level_rst", int'(fifo_level), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    z_in = 1;
    tick();
    chk("t6_prime_level", int'(fifo_level), 0);
    tick();
    z_in = 0;
    tick();
    chk("t6_after_level", int'(fifo_level), 1);

    // Randomized traffic with occasional mid-stream resets.
    for (int c = 0; c < 3000; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      ev_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) z_in = ~z_in;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_change_event_logger
`default_nettype wire
